// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encoding,
// instruction classes and the select constants that the datapath also uses.
package mc_controller_pkg;

    localparam logic [2:0] ST_FETCH    = 3'd0;
    localparam logic [2:0] ST_DECODE   = 3'd1;
    localparam logic [2:0] ST_EXEC     = 3'd2;
    localparam logic [2:0] ST_MEM      = 3'd3;
    localparam logic [2:0] ST_WB       = 3'd4;
    localparam logic [2:0] ST_MDU_WAIT = 3'd5;

    typedef enum logic [3:0] {
        CL_NOP, CL_ADD, CL_SUB, CL_ORI, CL_LW, CL_SW, CL_BEQ, CL_LUI,
        CL_J, CL_JAL, CL_JR, CL_MULT, CL_DIV, CL_MFHI, CL_MFLO
    } instr_class_t;

    localparam logic [2:0] ALUOP_ADD = 3'd0;
    localparam logic [2:0] ALUOP_SUB = 3'd1;
    localparam logic [2:0] ALUOP_OR  = 3'd2;
    localparam logic [2:0] ALUOP_LUI = 3'd3;
    localparam logic [2:0] ALUOP_NOP = 3'd7;

    localparam logic [1:0] NPC_NEXT   = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_J      = 2'd2;
    localparam logic [1:0] NPC_JR     = 2'd3;

    localparam logic [1:0] WA_RT = 2'd0;
    localparam logic [1:0] WA_RD = 2'd1;
    localparam logic [1:0] WA_RA = 2'd2;

    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_MEM  = 2'd1;
    localparam logic [1:0] WD_PC   = 2'd2;
    localparam logic [1:0] WD_HILO = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src;
        logic       ext_mode;
        logic [1:0] wa_sel;
        logic [1:0] wd_sel;
        logic [1:0] npc_mode;
        logic       mdu_op;
        logic       hilo_sel;
    } ctrl_sel_t;

endpackage

// File: rtl/mc_controller_if.sv
// Control bus between the multi-cycle controller and the MIPS datapath.
interface mc_controller_if;
  logic [5:0] opCode;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] aluOp;
  logic       aluSrcMux;
  logic       extMode;
  logic [1:0] regWAMux;
  logic [1:0] regWDMux;
  logic [1:0] npcMode;
  logic       pcWE;
  logic       irWE;
  logic       regWE;
  logic       memWE;
  logic       hiloWE;
  logic       mduStart;
  logic       mduOp;
  logic       hiloSel;
  logic       instrDone;

  modport master (
    output opCode, funct, zero,
    input  aluOp, aluSrcMux, extMode, regWAMux, regWDMux, npcMode,
           pcWE, irWE, regWE, memWE, hiloWE, mduStart, mduOp, hiloSel, instrDone
  );

  modport slave (
    input  opCode, funct, zero,
    output aluOp, aluSrcMux, extMode, regWAMux, regWDMux, npcMode,
           pcWE, irWE, regWE, memWE, hiloWE, mduStart, mduOp, hiloSel, instrDone
  );
endinterface

// File: rtl/mc_controller_decode.sv
// Combinational instruction decoder: opCode/funct -> instruction class and the
// datapath selects that class holds for its whole lifetime.
module mc_decode
  import mc_controller_pkg::*;
(
  input  logic [5:0]   opCode,
  input  logic [5:0]   funct,
  output instr_class_t cls,
  output ctrl_sel_t    sel
);

  // classify the encoding; anything unrecognised is a NOP
  always_comb begin
    cls = CL_NOP;
    case (opCode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  cls = CL_ADD;
          FN_SUB:  cls = CL_SUB;
          FN_JR:   cls = CL_JR;
          FN_MULT: cls = CL_MULT;
          FN_DIV:  cls = CL_DIV;
          FN_MFHI: cls = CL_MFHI;
          FN_MFLO: cls = CL_MFLO;
          default: cls = CL_NOP;
        endcase
      end
      OP_ORI:  cls = CL_ORI;
      OP_LW:   cls = CL_LW;
      OP_SW:   cls = CL_SW;
      OP_BEQ:  cls = CL_BEQ;
      OP_LUI:  cls = CL_LUI;
      OP_J:    cls = CL_J;
      OP_JAL:  cls = CL_JAL;
      default: cls = CL_NOP;
    endcase
  end

  // per-class datapath selects (ORI zero-extends, memory and branch sign-extend)
  always_comb begin
    sel.alu_op   = ALUOP_NOP;
    sel.alu_src  = 1'b0;
    sel.ext_mode = 1'b0;
    sel.wa_sel   = WA_RT;
    sel.wd_sel   = WD_ALU;
    sel.npc_mode = NPC_NEXT;
    sel.mdu_op   = 1'b0;
    sel.hilo_sel = 1'b0;
    case (cls)
      CL_ADD: begin sel.alu_op = ALUOP_ADD; sel.wa_sel = WA_RD; end
      CL_SUB: begin sel.alu_op = ALUOP_SUB; sel.wa_sel = WA_RD; end
      CL_ORI: begin sel.alu_op = ALUOP_OR;  sel.alu_src = 1'b1; end
      CL_LW: begin
        sel.alu_op = ALUOP_ADD; sel.alu_src = 1'b1; sel.ext_mode = 1'b1; sel.wd_sel = WD_MEM;
      end
      CL_SW:   begin sel.alu_op = ALUOP_ADD; sel.alu_src = 1'b1; sel.ext_mode = 1'b1; end
      CL_BEQ:  begin sel.alu_op = ALUOP_SUB; sel.ext_mode = 1'b1; sel.npc_mode = NPC_BRANCH; end
      CL_LUI:  begin sel.alu_op = ALUOP_LUI; sel.alu_src = 1'b1; end
      CL_J:    sel.npc_mode = NPC_J;
      CL_JAL:  begin sel.npc_mode = NPC_J; sel.wa_sel = WA_RA; sel.wd_sel = WD_PC; end
      CL_JR:   sel.npc_mode = NPC_JR;
      CL_MULT: sel.mdu_op = 1'b0;
      CL_DIV:  sel.mdu_op = 1'b1;
      CL_MFHI: begin sel.wa_sel = WA_RD; sel.wd_sel = WD_HILO; sel.hilo_sel = 1'b0; end
      CL_MFLO: begin sel.wa_sel = WA_RD; sel.wd_sel = WD_HILO; sel.hilo_sel = 1'b1; end
      default: sel.alu_op = ALUOP_NOP;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM with a parametrised multiply/divide wait phase.
// Enables are gated by state so every architectural write happens exactly once.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input logic            clk,
  input logic            reset,
  mc_controller_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  logic [2:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  instr_class_t     cls_s;
  ctrl_sel_t        sel_s;

  mc_decode u_decode (
    .opCode (bus.opCode),
    .funct  (bus.funct),
    .cls    (cls_s),
    .sel    (sel_s)
  );

  // state sequencing and MDU wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_FETCH;
      cnt_r   <= CNT_ZERO;
    end else begin
      case (state_r)
        ST_FETCH: state_r <= ST_DECODE;
        ST_DECODE: begin
          case (cls_s)
            CL_J, CL_JAL, CL_JR, CL_NOP: state_r <= ST_FETCH;
            default:                     state_r <= ST_EXEC;
          endcase
        end
        ST_EXEC: begin
          case (cls_s)
            CL_LW, CL_SW: state_r <= ST_MEM;
            CL_ADD, CL_SUB, CL_ORI, CL_LUI, CL_MFHI, CL_MFLO: state_r <= ST_WB;
            CL_MULT: begin state_r <= ST_MDU_WAIT; cnt_r <= MULT_LOAD; end
            CL_DIV:  begin state_r <= ST_MDU_WAIT; cnt_r <= DIV_LOAD;  end
            default: state_r <= ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (cls_s == CL_LW) state_r <= ST_WB;
          else                state_r <= ST_FETCH;
        end
        ST_WB: state_r <= ST_FETCH;
        ST_MDU_WAIT: begin
          if (cnt_r == CNT_ZERO) state_r <= ST_FETCH;
          else                   cnt_r   <= cnt_r - CNT_ONE;
        end
        default: state_r <= ST_FETCH;
      endcase
    end
  end

  // Moore outputs; reset forces everything quiet so an aborted instruction cannot write
  always_comb begin
    bus.pcWE      = 1'b0;
    bus.irWE      = 1'b0;
    bus.regWE     = 1'b0;
    bus.memWE     = 1'b0;
    bus.hiloWE    = 1'b0;
    bus.mduStart  = 1'b0;
    bus.instrDone = 1'b0;
    bus.aluOp     = ALUOP_NOP;
    bus.aluSrcMux = 1'b0;
    bus.extMode   = 1'b0;
    bus.regWAMux  = WA_RT;
    bus.regWDMux  = WD_ALU;
    bus.npcMode   = NPC_NEXT;
    bus.mduOp     = 1'b0;
    bus.hiloSel   = 1'b0;
    if (reset) begin
      bus.aluOp = ALUOP_NOP;
    end else begin
      bus.aluOp     = sel_s.alu_op;
      bus.aluSrcMux = sel_s.alu_src;
      bus.extMode   = sel_s.ext_mode;
      bus.regWAMux  = sel_s.wa_sel;
      bus.regWDMux  = sel_s.wd_sel;
      bus.npcMode   = (state_r == ST_FETCH) ? NPC_NEXT : sel_s.npc_mode;
      bus.mduOp     = sel_s.mdu_op;
      bus.hiloSel   = sel_s.hilo_sel;
      case (state_r)
        ST_FETCH: begin bus.irWE = 1'b1; bus.pcWE = 1'b1; end
        ST_DECODE: begin
          case (cls_s)
            CL_J, CL_JR: begin bus.pcWE = 1'b1; bus.instrDone = 1'b1; end
            CL_JAL: begin bus.pcWE = 1'b1; bus.regWE = 1'b1; bus.instrDone = 1'b1; end
            CL_NOP:  bus.instrDone = 1'b1;
            default: bus.instrDone = 1'b0;
          endcase
        end
        ST_EXEC: begin
          case (cls_s)
            CL_BEQ:         begin bus.pcWE = bus.zero; bus.instrDone = 1'b1; end
            CL_MULT, CL_DIV: bus.mduStart = 1'b1;
            default:         bus.mduStart = 1'b0;
          endcase
        end
        ST_MEM: begin
          if (cls_s == CL_SW) begin
            bus.memWE     = 1'b1;
            bus.instrDone = 1'b1;
          end else begin
            bus.memWE = 1'b0;
          end
        end
        ST_WB: begin bus.regWE = 1'b1; bus.instrDone = 1'b1; end
        ST_MDU_WAIT: begin
          if (cnt_r == CNT_ZERO) begin
            bus.hiloWE    = 1'b1;
            bus.instrDone = 1'b1;
          end else begin
            bus.hiloWE = 1'b0;
          end
        end
        default: bus.instrDone = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed and random instruction
// streams compared cycle by cycle against a cycle-index reference model.
module tb_mc_controller;

  localparam int C_NOP = 0, C_ADD = 1, C_SUB = 2, C_ORI = 3, C_LW = 4, C_SW = 5,
                 C_BEQ = 6, C_LUI = 7, C_J = 8, C_JAL = 9, C_JR = 10,
                 C_MULT = 11, C_DIV = 12, C_MFHI = 13, C_MFLO = 14;

  localparam logic [19:0] RST_VEC = {7'b0000000, 3'd7, 10'b0000000000};

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [5:0] op_s, fn_s;
  logic       z_s;
  logic       sel_b;
  int         tests = 0;
  int         fails = 0;
  int         mc_cur = 5;
  int         dc_cur = 10;

  always #5 clk = ~clk;

  mc_controller_if ifa ();
  mc_controller_if ifb ();

  assign ifa.opCode = op_s;
  assign ifa.funct  = fn_s;
  assign ifa.zero   = z_s;
  assign ifb.opCode = op_s;
  assign ifb.funct  = fn_s;
  assign ifb.zero   = z_s;

  mc_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa));
  mc_controller #(.MULT_CYCLES(2), .DIV_CYCLES(1), .CNT_W(4)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb));

  // {pcWE,irWE,regWE,memWE,hiloWE,mduStart,instrDone,aluOp,aluSrc,ext,WA,WD,npc,mduOp,hiloSel}
  logic [19:0] obs_a, obs_b, obs;
  assign obs_a = {ifa.pcWE, ifa.irWE, ifa.regWE, ifa.memWE, ifa.hiloWE, ifa.mduStart,
                  ifa.instrDone, ifa.aluOp, ifa.aluSrcMux, ifa.extMode, ifa.regWAMux,
                  ifa.regWDMux, ifa.npcMode, ifa.mduOp, ifa.hiloSel};
  assign obs_b = {ifb.pcWE, ifb.irWE, ifb.regWE, ifb.memWE, ifb.hiloWE, ifb.mduStart,
                  ifb.instrDone, ifb.aluOp, ifb.aluSrcMux, ifb.extMode, ifb.regWAMux,
                  ifb.regWDMux, ifb.npcMode, ifb.mduOp, ifb.hiloSel};
  assign obs = sel_b ? obs_b : obs_a;

  function automatic int n_cycles(input int c);
    case (c)
      C_J, C_JAL, C_JR, C_NOP: return 2;
      C_BEQ:  return 3;
      C_LW:   return 5;
      C_MULT: return 3 + mc_cur;
      C_DIV:  return 3 + dc_cur;
      default: return 4;
    endcase
  endfunction

  // expected outputs for cycle k (0 = fetch) of an n-cycle instruction of class c
  function automatic logic [19:0] expect_vec(input int c, input int k, input int n, input logic z);
    logic pc, ir, rw, mw, hw, ms, dn, asrc, ext, mdu, hs;
    logic [2:0] alu;
    logic [1:0] wa, wd, npc;
    bit is_mdu;
    is_mdu = (c == C_MULT) || (c == C_DIV);
    ir = (k == 0);
    pc = (k == 0) || ((c == C_J || c == C_JAL || c == C_JR) && k == 1) || (c == C_BEQ && k == 2 && z);
    rw = (c == C_JAL && k == 1) || (c == C_LW && k == 4) ||
         ((c inside {C_ADD, C_SUB, C_ORI, C_LUI, C_MFHI, C_MFLO}) && k == 3);
    mw = (c == C_SW) && k == 3;
    hw = is_mdu && k == n - 1;
    ms = is_mdu && k == 2;
    dn = (k == n - 1);
    alu = 3'd7; asrc = 1'b0; ext = 1'b0; wa = 2'd0; wd = 2'd0; npc = 2'd0; mdu = 1'b0; hs = 1'b0;
    case (c)
      C_ADD:  begin alu = 3'd0; wa = 2'd1; end
      C_SUB:  begin alu = 3'd1; wa = 2'd1; end
      C_ORI:  begin alu = 3'd2; asrc = 1'b1; end
      C_LW:   begin alu = 3'd0; asrc = 1'b1; ext = 1'b1; wd = 2'd1; end
      C_SW:   begin alu = 3'd0; asrc = 1'b1; ext = 1'b1; end
      C_BEQ:  begin alu = 3'd1; ext = 1'b1; npc = 2'd1; end
      C_LUI:  begin alu = 3'd3; asrc = 1'b1; end
      C_J:    npc = 2'd2;
      C_JAL:  begin npc = 2'd2; wa = 2'd2; wd = 2'd2; end
      C_JR:   npc = 2'd3;
      C_DIV:  mdu = 1'b1;
      C_MFHI: begin wa = 2'd1; wd = 2'd3; end
      C_MFLO: begin wa = 2'd1; wd = 2'd3; hs = 1'b1; end
      default: alu = 3'd7;
    endcase
    if (k == 0) npc = 2'd0;
    return {pc, ir, rw, mw, hw, ms, dn, alu, asrc, ext, wa, wd, npc, mdu, hs};
  endfunction

  task automatic check(input string tag, input int k, input logic [19:0] o, input logic [19:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%05h expected=%05h", tag, k, o, e);
    end
  endtask

  task automatic load_instr(input int c);
    fn_s = 6'($urandom);
    case (c)
      C_ADD:  begin op_s = 6'b000000; fn_s = 6'b100000; end
      C_SUB:  begin op_s = 6'b000000; fn_s = 6'b100010; end
      C_ORI:  op_s = 6'b001101;
      C_LW:   op_s = 6'b100011;
      C_SW:   op_s = 6'b101011;
      C_BEQ:  op_s = 6'b000100;
      C_LUI:  op_s = 6'b001111;
      C_J:    op_s = 6'b000010;
      C_JAL:  op_s = 6'b000011;
      C_JR:   begin op_s = 6'b000000; fn_s = 6'b001000; end
      C_MULT: begin op_s = 6'b000000; fn_s = 6'b011000; end
      C_DIV:  begin op_s = 6'b000000; fn_s = 6'b011010; end
      C_MFHI: begin op_s = 6'b000000; fn_s = 6'b010000; end
      C_MFLO: begin op_s = 6'b000000; fn_s = 6'b010010; end
      default: begin
        case ($urandom_range(0, 3))
          0: begin op_s = 6'b000000; fn_s = 6'b000000; end
          1: op_s = 6'b111111;
          2: begin op_s = 6'b000000; fn_s = 6'b100001; end
          default: op_s = 6'b001000;
        endcase
      end
    endcase
  endtask

  // zmode: 0/1 force zero, 2 randomise it every cycle
  task automatic run_instr(input int c, input int zmode, input int stop_at, input string tag);
    int n;
    logic z;
    n = n_cycles(c);
    load_instr(c);
    for (int k = 0; k < n && k < stop_at; k++) begin
      z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      z_s = z;
      @(negedge clk);
      check(tag, k, obs, expect_vec(c, k, n, z));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; sel_b = 1'b0;
    op_s = 6'b000000; fn_s = 6'b000000; z_s = 1'b0;
    repeat (3) begin @(negedge clk); check("reset_hold", 0, obs, RST_VEC); end
    @(posedge clk); #1; rst_a = 1'b0;

    run_instr(C_ADD, 2, 99, "add");
    run_instr(C_LW, 2, 3, "lw_abort");
    rst_a = 1'b1;
    #1 check("reset_async", 3, obs, RST_VEC);
    repeat (3) begin @(negedge clk); check("reset_mid", 0, obs, RST_VEC); end
    @(posedge clk); #1; rst_a = 1'b0;

    run_instr(C_LW, 2, 99, "lw");
    run_instr(C_SW, 2, 99, "sw");
    run_instr(C_BEQ, 1, 99, "beq_taken");
    run_instr(C_BEQ, 0, 99, "beq_not_taken");
    run_instr(C_JAL, 2, 99, "jal");
    run_instr(C_MULT, 2, 99, "mult");
    run_instr(C_MFLO, 2, 99, "mflo");
    run_instr(C_MFHI, 2, 99, "mfhi");
    run_instr(C_DIV, 2, 99, "div");
    run_instr(C_J, 2, 99, "j");
    run_instr(C_JR, 2, 99, "jr");
    run_instr(C_NOP, 2, 99, "nop");
    run_instr(C_SUB, 2, 99, "sub");
    run_instr(C_ORI, 2, 99, "ori");
    run_instr(C_LUI, 2, 99, "lui");
    for (int i = 0; i < 200; i++) run_instr(int'($urandom_range(0, 14)), 2, 99, "rand_a");

    rst_a = 1'b1; sel_b = 1'b1; mc_cur = 2; dc_cur = 1;
    repeat (2) begin @(negedge clk); check("reset_b", 0, obs, RST_VEC); end
    @(posedge clk); #1; rst_b = 1'b0;
    run_instr(C_DIV, 2, 99, "div_short");
    run_instr(C_MULT, 2, 99, "mult_short");
    run_instr(C_BEQ, 1, 99, "beq_b");
    for (int i = 0; i < 60; i++) run_instr(int'($urandom_range(0, 14)), 2, 99, "rand_b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
